// File: rtl/mux_rr_scheduler_if.sv
// rtl/mux_rr_scheduler_if.sv - request/grant/select bundle between requesters and the mux scheduler
interface mux_rr_scheduler_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic       sel2;
   logic       sel1;
   logic       sel0;
   logic       busy;

   modport master (
      output req,
      input  gnt,
      input  sel2,
      input  sel1,
      input  sel0,
      input  busy
   );

   modport slave (
      input  req,
      output gnt,
      output sel2,
      output sel1,
      output sel0,
      output busy
   );
endinterface

// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin owner of an 8:1 bit mux with bounded grant bursts
module mux_rr_scheduler #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   mux_rr_scheduler_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state_q;
   logic [2:0] ptr_q;
   logic [2:0] cur_q;
   logic [7:0] hold_cnt_q;
   logic [7:0] gnt_q;
   logic [2:0] sel_q;
   logic       busy_q;

   logic [2:0] pick_idle_d;
   logic [2:0] pick_next_d;
   logic [2:0] cur_inc_d;
   logic       any_req_d;
   logic       release_d;

   // First requester at or after start, wrapping modulo 8.
   function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] start);
      logic [2:0] idx;
      logic [2:0] res;
      res = start;
      for (int k = 7; k >= 0; k--) begin
         idx = start + k[2:0];
         if (r[idx]) begin
            res = idx;
         end
      end
      return res;
   endfunction

   always_comb begin
      cur_inc_d   = cur_q + 3'd1;
      any_req_d   = |bus.req;
      pick_idle_d = pick(bus.req, ptr_q);
      pick_next_d = pick(bus.req, cur_inc_d);
      release_d   = !bus.req[cur_q] || (hold_cnt_q == 8'(MAX_HOLD));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= 3'd0;
         cur_q      <= 3'd0;
         hold_cnt_q <= 8'd0;
         gnt_q      <= 8'h00;
         sel_q      <= 3'd0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req_d) begin
                  state_q    <= GRANT;
                  cur_q      <= pick_idle_d;
                  gnt_q      <= 8'd1 << pick_idle_d;
                  sel_q      <= pick_idle_d;
                  hold_cnt_q <= 8'd1;
                  busy_q     <= 1'b1;
               end
            end
            GRANT: begin
               if (release_d) begin
                  ptr_q <= cur_inc_d;
                  // The outgoing grantee is scanned last, so it only wins again when alone.
                  if (any_req_d) begin
                     cur_q      <= pick_next_d;
                     gnt_q      <= 8'd1 << pick_next_d;
                     sel_q      <= pick_next_d;
                     hold_cnt_q <= 8'd1;
                     busy_q     <= 1'b1;
                  end else begin
                     state_q    <= IDLE;
                     gnt_q      <= 8'h00;
                     hold_cnt_q <= 8'd0;
                     busy_q     <= 1'b0;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= 8'h00;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Select lines hold their value while idle so the mux input stays quiet.
   assign bus.gnt  = gnt_q;
   assign bus.sel2 = sel_q[2];
   assign bus.sel1 = sel_q[1];
   assign bus.sel0 = sel_q[0];
   assign bus.busy = busy_q;

endmodule
